// File: rtl/adc_scan_ctrl_if.sv
// Handshake bundle between the scan scheduler and the spi ADC128S022 core.
// The scheduler is the master: it drives start/channel and receives done/data.
interface adc_scan_ctrl_if;
  logic        adc_start;
  logic [2:0]  adc_channel;
  logic        adc_done;
  logic [11:0] adc_data;

  modport master (output adc_start, output adc_channel, input adc_done, input adc_data);
  modport slave  (input adc_start, input adc_channel, output adc_done, output adc_data);
endinterface

// File: rtl/adc_scan_ctrl.sv
// Scan scheduler: walks an 8-bit channel mask over the spi ADC core, re-tags the
// one-frame-late results with their true channel, streams them and keeps a readback file.
module adc_scan_ctrl #(
  parameter int PERIOD  = 50000,
  parameter int GAP     = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  trig,
  input  logic [7:0]            ch_mask,
  input  logic                  err_clr,
  adc_scan_ctrl_if.master       adc,
  output logic                  smp_valid,
  output logic [2:0]            smp_ch,
  output logic [11:0]           smp_data,
  output logic                  scan_done,
  output logic                  busy,
  input  logic [2:0]            rd_ch,
  output logic [11:0]           rd_data,
  output logic                  err_ovr,
  output logic                  err_to
);

  localparam int TMR_W = $clog2(PERIOD);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP, ST_DONE, ST_ABORT
  } state_t;

  state_t           state_r, state_next_s;
  logic [TMR_W-1:0] tmr_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [7:0]       mask_q_r;
  logic [3:0]       frm_cnt_r;
  logic [2:0]       adc_ch_r, prev_ch_r;
  logic             adc_start_r, busy_r, scan_done_r, smp_valid_r;
  logic [2:0]       smp_ch_r;
  logic [11:0]      smp_data_r;
  logic             err_ovr_r, err_to_r;
  logic [11:0]      rf_r [8];

  logic req_s, accept_s, ovr_s, cap_s, frames_left_s;

  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, m[i]};
    return c;
  endfunction

  // Lowest set bit strictly above cur, wrapping; starting from 7 yields the first enabled channel.
  function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r, idx;
    r = cur;
    for (int i = 7; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  assign req_s         = trig | (en & (tmr_r == TMR_LAST));
  assign accept_s      = (state_r == ST_IDLE) & req_s & (ch_mask != 8'd0);
  assign ovr_s         = (state_r != ST_IDLE) & req_s;
  assign cap_s         = (state_r == ST_WAIT) & adc.adc_done;
  assign frames_left_s = (frm_cnt_r <= popcount8(mask_q_r));

  // Free-running period timer, held at zero while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n)                tmr_r <= '0;
    else if (!en)              tmr_r <= '0;
    else if (tmr_r == TMR_LAST) tmr_r <= '0;
    else                       tmr_r <= tmr_r + TMR_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  if (accept_s) state_next_s = ST_ISSUE; else state_next_s = ST_IDLE;
      ST_ISSUE: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (adc.adc_done)           state_next_s = ST_GAP;
        else if (to_cnt_r == TO_LAST) state_next_s = ST_ABORT;
        else                        state_next_s = ST_WAIT;
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          if (frames_left_s) state_next_s = ST_ISSUE;
          else               state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_GAP;
        end
      end
      ST_DONE:  state_next_s = ST_IDLE;
      ST_ABORT: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Timeout counter runs from the start pulse; gap counter runs only inside GAP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_r  <= '0;
      gap_cnt_r <= '0;
    end else begin
      if (state_next_s == ST_ISSUE)                         to_cnt_r <= '0;
      else if (state_r == ST_ISSUE || state_r == ST_WAIT)   to_cnt_r <= to_cnt_r + TO_W'(1);
      else                                                  to_cnt_r <= to_cnt_r;
      if (state_r == ST_GAP && state_next_s == ST_GAP) gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      else                                             gap_cnt_r <= '0;
    end
  end

  // Frame sequencing, channel addressing, result re-tagging and register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adc_start_r <= 1'b0;
      busy_r      <= 1'b0;
      scan_done_r <= 1'b0;
      smp_valid_r <= 1'b0;
      smp_ch_r    <= 3'd0;
      smp_data_r  <= 12'd0;
      mask_q_r    <= 8'd0;
      frm_cnt_r   <= 4'd0;
      adc_ch_r    <= 3'd0;
      prev_ch_r   <= 3'd0;
      for (int i = 0; i < 8; i++) rf_r[i] <= 12'd0;
    end else begin
      adc_start_r <= (state_next_s == ST_ISSUE);
      busy_r      <= (state_next_s != ST_IDLE);
      scan_done_r <= (state_next_s == ST_DONE);
      smp_valid_r <= cap_s && (frm_cnt_r != 4'd0);
      if (accept_s) begin
        mask_q_r  <= ch_mask;
        frm_cnt_r <= 4'd0;
      end
      if (state_next_s == ST_ISSUE) begin
        prev_ch_r <= adc_ch_r;
        if (state_r == ST_IDLE) adc_ch_r <= next_ch(ch_mask, 3'd7);
        else                    adc_ch_r <= next_ch(mask_q_r, adc_ch_r);
      end
      // Data arriving in frame k belongs to the channel addressed in frame k-1.
      if (cap_s) begin
        frm_cnt_r <= frm_cnt_r + 4'd1;
        if (frm_cnt_r != 4'd0) begin
          smp_ch_r        <= prev_ch_r;
          smp_data_r      <= adc.adc_data;
          rf_r[prev_ch_r] <= adc.adc_data;
        end
      end
    end
  end

  // Sticky error flags; a fresh event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_ovr_r <= 1'b0;
      err_to_r  <= 1'b0;
    end else begin
      if (ovr_s)        err_ovr_r <= 1'b1;
      else if (err_clr) err_ovr_r <= 1'b0;
      else              err_ovr_r <= err_ovr_r;
      if (state_next_s == ST_ABORT) err_to_r <= 1'b1;
      else if (err_clr)             err_to_r <= 1'b0;
      else                          err_to_r <= err_to_r;
    end
  end

  assign adc.adc_start   = adc_start_r;
  assign adc.adc_channel = adc_ch_r;
  assign smp_valid       = smp_valid_r;
  assign smp_ch          = smp_ch_r;
  assign smp_data        = smp_data_r;
  assign scan_done       = scan_done_r;
  assign busy            = busy_r;
  assign err_ovr         = err_ovr_r;
  assign err_to          = err_to_r;
  assign rd_data         = rf_r[rd_ch];

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: an ADC responder plus a mask-walk reference model
// built from the scan rules (frame list = enabled channels plus first channel again).
module tb_adc_scan_ctrl;
  localparam int PERIOD = 200, GAP = 10, TIMEOUT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, trig, err_clr, smp_valid, scan_done, busy, err_ovr, err_to;
  logic [7:0]  ch_mask;
  logic [2:0]  smp_ch, rd_ch;
  logic [11:0] smp_data, rd_data;

  adc_scan_ctrl_if bus ();

  adc_scan_ctrl #(.PERIOD(PERIOD), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .ch_mask(ch_mask), .err_clr(err_clr),
    .adc(bus), .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data),
    .scan_done(scan_done), .busy(busy), .rd_ch(rd_ch), .rd_data(rd_data),
    .err_ovr(err_ovr), .err_to(err_to)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC responder: data for frame k of the current scan is data_tab[k].
  bit          resp_en = 1'b1;
  int          lat = 5;
  logic [11:0] data_tab [16];
  int          frm_base = 0;
  int          n_start = 0;
  bit          pend = 1'b0;
  int          lat_cnt = 0;
  int          tag = 0;
  always @(posedge clk) begin
    bus.adc_done <= 1'b0;
    if (pend) begin
      if (lat_cnt == 0) begin
        bus.adc_done <= 1'b1;
        bus.adc_data <= data_tab[tag & 15];
        pend         <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
    if (bus.adc_start === 1'b1) begin
      n_start <= n_start + 1;
      if (resp_en) begin
        pend    <= 1'b1;
        lat_cnt <= lat - 1;
        tag     <= n_start - frm_base;
      end
    end
  end

  int st_ch_q[$], st_cyc_q[$], dn_cyc_q[$], sm_ch_q[$], sm_dat_q[$], sm_cyc_q[$], sd_cyc_q[$];
  always @(negedge clk) begin
    if (bus.adc_start === 1'b1) begin
      st_ch_q.push_back(int'(bus.adc_channel));
      st_cyc_q.push_back(cyc);
    end
    if (bus.adc_done === 1'b1) dn_cyc_q.push_back(cyc);
    if (smp_valid === 1'b1) begin
      sm_ch_q.push_back(int'(smp_ch));
      sm_dat_q.push_back(int'(smp_data));
      sm_cyc_q.push_back(cyc);
    end
    if (scan_done === 1'b1) sd_cyc_q.push_back(cyc);
  end

  int b_st, b_dn, b_sm, b_sd;
  int exp_rf [8];

  function automatic int qget(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic void build_list(input logic [7:0] m, output int lst[$]);
    lst = {};
    for (int c = 0; c < 8; c++) if (m[c]) lst.push_back(c);
  endfunction

  task automatic mark();
    b_st = st_ch_q.size(); b_dn = dn_cyc_q.size(); b_sm = sm_ch_q.size(); b_sd = sd_cyc_q.size();
    frm_base = n_start;
  endtask

  task automatic pulse_trig();
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok, output int at);
    ok = 1'b0; at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.adc_start, bus.adc_channel, smp_valid, smp_ch, smp_data, scan_done, busy, err_ovr, err_to} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {bus.adc_start, bus.adc_channel, smp_valid, smp_ch, smp_data, scan_done, busy, err_ovr, err_to});
    end
    for (int i = 0; i < 8; i++) begin
      rd_ch = 3'(i); #1;
      checks++;
      if (rd_data !== 12'd0) begin errors++; $display("FAIL reset_rf[%0d]: got %h required 0", i, rd_data); end
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; int at;
    ch_mask = 8'h08; lat = 5;
    data_tab[0] = 12'h111; data_tab[1] = 12'h222;
    mark();
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    checks++;
    if ({bus.adc_start, busy, bus.adc_channel} !== {1'b1, 1'b1, 3'd3}) begin
      errors++; $display("FAIL single_first_issue: got %b required 1_1_011", {bus.adc_start, busy, bus.adc_channel});
    end
    wait_idle(1000, ok, at);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle: got busy required idle"); end
    checks++;
    if (st_ch_q.size() - b_st != 2) begin errors++; $display("FAIL single_starts: got %0d required 2", st_ch_q.size() - b_st); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (qget(st_ch_q, b_st + k) != 3) begin errors++; $display("FAIL single_ch[%0d]: got %0d required 3", k, qget(st_ch_q, b_st + k)); end
    end
    checks++;
    if (sm_ch_q.size() - b_sm != 1 || qget(sm_ch_q, b_sm) != 3 || qget(sm_dat_q, b_sm) != 'h222) begin
      errors++; $display("FAIL single_sample: got n=%0d ch=%0d data=%h required n=1 ch=3 data=222",
                         sm_ch_q.size() - b_sm, qget(sm_ch_q, b_sm), qget(sm_dat_q, b_sm));
    end
    exp_rf[3] = 'h222;
    rd_ch = 3'd3; #1;
    checks++; if (rd_data !== 12'h222) begin errors++; $display("FAIL single_rd: got %h required 222", rd_data); end
    checks++;
    if (sd_cyc_q.size() - b_sd != 1) begin errors++; $display("FAIL single_scan_done: got %0d required 1", sd_cyc_q.size() - b_sd); end
  endtask

  task automatic test_multi();
    int lst[$]; int n, exp_c, last_dn; bit ok; int at;
    ch_mask = 8'hA5; lat = 7;
    for (int k = 0; k < 16; k++) data_tab[k] = 12'(12'h100 + k);
    build_list(8'hA5, lst); n = lst.size();
    mark(); pulse_trig(); wait_idle(2000, ok, at);
    checks++; if (!ok) begin errors++; $display("FAIL multi_idle: got busy required idle"); end
    checks++;
    if (st_ch_q.size() - b_st != n + 1) begin errors++; $display("FAIL multi_starts: got %0d required %0d", st_ch_q.size() - b_st, n + 1); end
    for (int k = 0; k <= n; k++) begin
      exp_c = (k < n) ? lst[k] : lst[0];
      checks++;
      if (qget(st_ch_q, b_st + k) != exp_c) begin errors++; $display("FAIL multi_ch[%0d]: got %0d required %0d", k, qget(st_ch_q, b_st + k), exp_c); end
      if (k >= 1) begin
        checks++;
        if (qget(st_cyc_q, b_st + k) != qget(dn_cyc_q, b_dn + k - 1) + 1 + GAP) begin
          errors++; $display("FAIL multi_gap[%0d]: got %0d required %0d", k, qget(st_cyc_q, b_st + k), qget(dn_cyc_q, b_dn + k - 1) + 1 + GAP);
        end
      end
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (qget(sm_ch_q, b_sm + k) != lst[k] || qget(sm_dat_q, b_sm + k) != 'h100 + k + 1 ||
          qget(sm_cyc_q, b_sm + k) != qget(dn_cyc_q, b_dn + k + 1) + 1) begin
        errors++; $display("FAIL multi_sample[%0d]: got ch=%0d data=%h required ch=%0d data=%h", k,
                           qget(sm_ch_q, b_sm + k), qget(sm_dat_q, b_sm + k), lst[k], 'h100 + k + 1);
      end
      exp_rf[lst[k]] = 'h100 + k + 1;
    end
    last_dn = qget(dn_cyc_q, b_dn + n);
    checks++;
    if (sd_cyc_q.size() - b_sd != 1 || qget(sd_cyc_q, b_sd) != last_dn + 1 + GAP) begin
      errors++; $display("FAIL multi_scan_done: got cyc %0d required %0d", qget(sd_cyc_q, b_sd), last_dn + 1 + GAP);
    end
    checks++;
    if (at != last_dn + 2 + GAP) begin errors++; $display("FAIL multi_busy_fall: got %0d required %0d", at, last_dn + 2 + GAP); end
  endtask

  task automatic test_random();
    int lst[$]; int n, exp_c; logic [7:0] m; bit ok; int at;
    for (int it = 0; it < 6; it++) begin
      m = 8'($urandom_range(1, 255));
      lat = $urandom_range(1, 30);
      for (int k = 0; k < 16; k++) data_tab[k] = 12'($urandom);
      build_list(m, lst); n = lst.size();
      ch_mask = m;
      mark(); pulse_trig();
      ch_mask = 8'($urandom);
      wait_idle(3000, ok, at);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_idle: got busy required idle", it); end
      checks++;
      if (st_ch_q.size() - b_st != n + 1 || sm_ch_q.size() - b_sm != n || sd_cyc_q.size() - b_sd != 1) begin
        errors++; $display("FAIL rand%0d_counts: got starts=%0d smp=%0d done=%0d required %0d %0d 1", it,
                           st_ch_q.size() - b_st, sm_ch_q.size() - b_sm, sd_cyc_q.size() - b_sd, n + 1, n);
      end
      for (int k = 0; k <= n; k++) begin
        exp_c = (k < n) ? lst[k] : lst[0];
        checks++;
        if (qget(st_ch_q, b_st + k) != exp_c) begin errors++; $display("FAIL rand%0d_ch[%0d]: got %0d required %0d", it, k, qget(st_ch_q, b_st + k), exp_c); end
      end
      for (int k = 0; k < n; k++) begin
        checks++;
        if (qget(sm_ch_q, b_sm + k) != lst[k] || qget(sm_dat_q, b_sm + k) != int'(data_tab[k + 1])) begin
          errors++; $display("FAIL rand%0d_sample[%0d]: got ch=%0d data=%h required ch=%0d data=%h", it, k,
                             qget(sm_ch_q, b_sm + k), qget(sm_dat_q, b_sm + k), lst[k], data_tab[k + 1]);
        end
        exp_rf[lst[k]] = int'(data_tab[k + 1]);
      end
      for (int c = 0; c < 8; c++) begin
        rd_ch = 3'(c); #1;
        checks++;
        if (int'(rd_data) != exp_rf[c]) begin errors++; $display("FAIL rand%0d_rd[%0d]: got %h required %h", it, c, rd_data, exp_rf[c]); end
      end
    end
  endtask

  task automatic test_mask_zero();
    ch_mask = 8'h00;
    mark(); pulse_trig();
    repeat (20) @(negedge clk);
    checks++;
    if (st_ch_q.size() - b_st != 0 || busy !== 1'b0 || err_ovr !== 1'b0 || sd_cyc_q.size() - b_sd != 0) begin
      errors++; $display("FAIL mask_zero: got starts=%0d busy=%b ovr=%b required 0 0 0", st_ch_q.size() - b_st, busy, err_ovr);
    end
  endtask

  task automatic test_periodic();
    int e, at; bit ok, seen;
    lat = 40; ch_mask = 8'hFF;
    for (int k = 0; k < 16; k++) data_tab[k] = 12'($urandom);
    mark();
    @(negedge clk); en = 1'b1; e = cyc;
    seen = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (err_ovr === 1'b1) begin seen = 1'b1; at = cyc; break; end
    end
    checks++;
    if (qget(st_cyc_q, b_st) != e + PERIOD) begin errors++; $display("FAIL periodic_first: got %0d required %0d", qget(st_cyc_q, b_st), e + PERIOD); end
    checks++;
    if (!seen || at != e + 2 * PERIOD) begin errors++; $display("FAIL periodic_ovr: got %0d required %0d", seen ? at : -1, e + 2 * PERIOD); end
    en = 1'b0;
    @(negedge clk); trig = 1'b1; err_clr = 1'b1;
    @(negedge clk); trig = 1'b0; err_clr = 1'b0;
    checks++; if (err_ovr !== 1'b1) begin errors++; $display("FAIL ovr_beats_clr: got %b required 1", err_ovr); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    checks++; if (err_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b required 0", err_ovr); end
    wait_idle(2000, ok, at);
    checks++;
    if (!ok || st_ch_q.size() - b_st != 9 || sm_ch_q.size() - b_sm != 8 || sd_cyc_q.size() - b_sd != 1) begin
      errors++; $display("FAIL periodic_scan: got starts=%0d smp=%0d done=%0d required 9 8 1",
                         st_ch_q.size() - b_st, sm_ch_q.size() - b_sm, sd_cyc_q.size() - b_sd);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (qget(sm_ch_q, b_sm + k) != k || qget(sm_dat_q, b_sm + k) != int'(data_tab[k + 1])) begin
        errors++; $display("FAIL periodic_sample[%0d]: got ch=%0d data=%h required ch=%0d data=%h", k,
                           qget(sm_ch_q, b_sm + k), qget(sm_dat_q, b_sm + k), k, data_tab[k + 1]);
      end
    end
  endtask

  task automatic test_timeout();
    int at, n; bit ok, seen; int lst[$]; logic [7:0] m;
    resp_en = 1'b0; m = 8'($urandom_range(1, 255)); ch_mask = m;
    mark(); pulse_trig();
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (err_to === 1'b1) begin seen = 1'b1; at = cyc; break; end
    end
    checks++;
    if (!seen || at != qget(st_cyc_q, b_st) + TIMEOUT) begin
      errors++; $display("FAIL timeout_at: got %0d required %0d", seen ? at : -1, qget(st_cyc_q, b_st) + TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sd_cyc_q.size() - b_sd != 0 || st_ch_q.size() - b_st != 1) begin
      errors++; $display("FAIL timeout_abort: got busy=%b done=%0d starts=%0d required 0 0 1", busy, sd_cyc_q.size() - b_sd, st_ch_q.size() - b_st);
    end
    resp_en = 1'b1; lat = 3;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    checks++; if (err_to !== 1'b0) begin errors++; $display("FAIL timeout_clr: got %b required 0", err_to); end
    build_list(m, lst); n = lst.size();
    mark(); pulse_trig(); wait_idle(2000, ok, at);
    checks++;
    if (!ok || sd_cyc_q.size() - b_sd != 1 || sm_ch_q.size() - b_sm != n || err_to !== 1'b0) begin
      errors++; $display("FAIL timeout_recover: got done=%0d smp=%0d to=%b required 1 %0d 0", sd_cyc_q.size() - b_sd, sm_ch_q.size() - b_sm, err_to, n);
    end
  endtask

  task automatic test_reset_mid();
    lat = 30; ch_mask = 8'h3C;
    mark(); pulse_trig();
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.adc_start, bus.adc_channel, smp_valid, smp_ch, smp_data, scan_done, busy, err_ovr, err_to} !== 24'd0) begin
      errors++; $display("FAIL midrst_outputs: got %h required 0",
                         {bus.adc_start, bus.adc_channel, smp_valid, smp_ch, smp_data, scan_done, busy, err_ovr, err_to});
    end
    for (int c = 0; c < 8; c++) begin
      rd_ch = 3'(c); #1;
      checks++;
      if (rd_data !== 12'd0) begin errors++; $display("FAIL midrst_rf[%0d]: got %h required 0", c, rd_data); end
    end
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (sm_ch_q.size() - b_sm != 0 || busy !== 1'b0 || st_ch_q.size() - b_st != 1) begin
      errors++; $display("FAIL midrst_late_done: got smp=%0d busy=%b starts=%0d required 0 0 1", sm_ch_q.size() - b_sm, busy, st_ch_q.size() - b_st);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; trig = 1'b0; err_clr = 1'b0; ch_mask = 8'h00; rd_ch = 3'd0;
    for (int i = 0; i < 8; i++) exp_rf[i] = 0;
    for (int k = 0; k < 16; k++) data_tab[k] = 12'd0;
    test_reset();
    test_single();
    test_multi();
    test_random();
    test_mask_zero();
    test_periodic();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Scan scheduler for the `spi` ADC128S022 controller core. It drives that core's `start`/`channel` inputs and collects its `done`/`data` outputs, and walks an 8-bit channel mask either periodically or on a trigger. The ADC returns each result one frame after the channel is addressed, so the block re-tags every result with its true channel. Results are streamed out as tagged samples and also held in an 8-entry register file for host readback.

## Interface
Parameters:
- `PERIOD`, default 50000: clk cycles between periodic scan requests, minimum 2.
- `GAP`, default 10: idle clk cycles between `done` and the next `adc_start`.
- `TIMEOUT`, default 4096: clk cycles allowed from `adc_start` to `adc_done` before abort.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: enable periodic scanning.
- `trig` in 1: one-cycle request for a single scan.
- `ch_mask` in 8: enabled channels, bit n = channel n.
- `err_clr` in 1: clears the sticky error flags.
- `adc_start` out 1: one-cycle start pulse to the `spi` core.
- `adc_channel` out 3: channel address to the `spi` core.
- `adc_done` in 1: one-cycle conversion-complete pulse from the `spi` core.
- `adc_data` in 12: conversion result, valid while `adc_done`=1.
- `smp_valid` out 1: one-cycle sample strobe.
- `smp_ch` out 3: channel the sample belongs to.
- `smp_data` out 12: sample value.
- `scan_done` out 1: one-cycle pulse when a scan completes.
- `busy` out 1: high while a scan is in progress.
- `rd_ch` in 3: readback channel select.
- `rd_data` out 12: last result for `rd_ch`, combinational read.
- `err_ovr` out 1: sticky; a scan request arrived while `busy`.
- `err_to` out 1: sticky; a frame timed out.

## Operation
- Period timer: free-running counter that counts only while `en`=1 and clears when `en`=0. On reaching `PERIOD-1` it raises a request and wraps to 0.
- A scan request is the timer request or `trig`. Both in the same cycle count as one request.
- Request while `busy`=1: the request is dropped and `err_ovr` is set.
- Request in IDLE with `ch_mask`=0: ignored. No frames, no `scan_done`, no error.
- At scan start `ch_mask` is latched into `mask_q`. Later changes to `ch_mask` take effect at the next scan.
- Channel order: ascending index over `mask_q`.
- Frame pipeline, with N = popcount(`mask_q`):
  - Frame k addresses enabled channel k. Frame 0 addresses the first enabled channel and its data is discarded as the priming frame.
  - Frame k≥1 returns data for the channel addressed in frame k-1.
  - The scan issues N+1 frames. Frame N re-addresses the first enabled channel.
- States:
  - IDLE → ISSUE on an accepted request.
  - ISSUE (1 cycle) asserts `adc_start` → WAIT.
  - WAIT → GAP on `adc_done`. On the same edge the result is captured unless this is frame 0. WAIT → ABORT when the timeout counter reaches `TIMEOUT-1`.
  - GAP counts `GAP` cycles, then → ISSUE if frames remain, else → DONE.
  - DONE (1 cycle) pulses `scan_done` → IDLE.
  - ABORT sets `err_to` and → IDLE. No `scan_done`; results already written are kept.
- `adc_channel` is registered and held stable from ISSUE until the next ISSUE.
- `adc_done` outside WAIT is ignored.
- `err_clr` clears both flags. A new error event in the same cycle wins, so the flag stays set.

## Timing
- Reset values: `adc_start`, `smp_valid`, `scan_done`, `busy`, `err_ovr`, `err_to` = 0; `adc_channel`, `smp_ch`, `smp_data` = 0; all register-file entries = 0; timer = 0; state IDLE.
- `rst_n` low mid-scan aborts the scan at the next edge. Any in-flight `adc_done` after reset is ignored.
- Accepted request at edge t: `busy`=1 and `adc_start`=1 from t+1. `adc_channel` is valid at t+1.
- `adc_done` at cycle d: `smp_valid`, `smp_ch`, `smp_data` and the register-file write all appear at d+1.
- `adc_done` at cycle d: next `adc_start` at d+1+`GAP`.
- Last `adc_done` at d: `scan_done`=1 at d+1+`GAP`; `busy` falls at d+2+`GAP`.
- With N enabled channels: exactly N `smp_valid` pulses and N+1 `adc_start` pulses per scan.

## Test plan
- Single channel: `ch_mask`=8'h08, pulse `trig`; ADC model returns 12'h111 then 12'h222. Required: 2 `adc_start` pulses, both with `adc_channel`=3; exactly 1 `smp_valid` with `smp_ch`=3, `smp_data`=12'h222; `rd_data`(3)=12'h222; one `scan_done`.
- Multi-channel tagging: `ch_mask`=8'hA5, model returns value = 12'h100 + frame index. Required: `adc_channel` sequence 0,2,5,7,0; samples (0,101),(2,102),(5,103),(7,104); `scan_done` after the 5th frame.
- Periodic with overrun: `PERIOD`=200, `ch_mask`=8'hFF, model latency 40 cycles. Required: first scan starts at cycle 200; the second request arrives while `busy` and is dropped with `err_ovr`=1; `err_clr` clears it.
- Timeout: `TIMEOUT`=64, model never asserts `adc_done`. Required: `err_to`=1 at 64 cycles after `adc_start`; `busy`=0; no `scan_done`; the next `trig` runs normally.
- Mask edge cases: `trig` with `ch_mask`=0 produces no `adc_start`. Changing `ch_mask` mid-scan does not alter that scan's channel sequence.
- Reset mid-scan: drop `rst_n` during WAIT. Required: all outputs at their reset values on the next edge; a late `adc_done` produces no `smp_valid`.
